// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module   : mux_scan_pkg
// Purpose  : Shared FSM states and sizing constants for the mux scan controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

   localparam int NUM_CH   = 4;
   localparam int CH_W     = 2;
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_scan_settle_timer.sv
// ============================================================================
// Module   : mux_scan_settle_timer
// Purpose  : Counts 0..SETTLE while enabled; done marks the last cycle of a channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_settle_timer
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [SETTLE_W-1:0] C_LAST = SETTLE_W'(SETTLE);

   logic [SETTLE_W-1:0] r_cnt;

   assign done = en && (r_cnt == C_LAST);

   // Wraps to zero on done so the next channel starts a fresh settle window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr || done) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Steps the 4:1 mux selects, samples d per channel, and hands out
//            the packed 4-bit word on a valid/ready interface.
//            Optional parity output enabled by MUX_SCAN_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       d,
   output logic       s1,
   output logic       s2,
   output logic       busy,
   output logic       word_valid,
   input  logic       word_ready,
   output logic [NUM_CH-1:0] word
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic       word_par
`endif
);

   localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NUM_CH - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CH_W-1:0]     r_ch;
   logic [CH_W-1:0]     w_ch_nxt;
   logic [CH_W-1:0]     r_sel;
   logic [CH_W-1:0]     w_sel_nxt;
   logic [NUM_CH-1:0]   r_word;
   logic [NUM_CH-1:0]   w_word_nxt;
   logic                r_valid;
   logic                w_valid_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                w_tmr_clr;
   logic                w_tmr_en;
   logic                w_tmr_done;
`ifdef MUX_SCAN_PARITY_EN
   logic                r_par;
   logic                w_par_nxt;
`endif

   mux_scan_settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_tmr_clr),
      .en    (w_tmr_en),
      .done  (w_tmr_done)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_sel_nxt   = r_sel;
      w_word_nxt  = r_word;
      w_valid_nxt = r_valid;
      w_busy_nxt  = r_busy;
      w_tmr_clr   = 1'b0;
      w_tmr_en    = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = SCAN;
               w_ch_nxt    = '0;
               w_sel_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_tmr_clr   = 1'b1;
            end
         end
         SCAN: begin
            w_tmr_en = 1'b1;
            if (w_tmr_done) begin
               w_word_nxt[r_ch] = d;
               if (r_ch == C_LAST_CH) begin
                  // Selects park at channel 0 while the word waits downstream.
                  w_state_nxt = HOLD;
                  w_sel_nxt   = '0;
                  w_valid_nxt = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                  w_par_nxt   = ^w_word_nxt;
`endif
               end else begin
                  w_ch_nxt  = r_ch + 1'b1;
                  w_sel_nxt = r_ch + 1'b1;
               end
            end
         end
         HOLD: begin
            if (r_valid && word_ready) begin
               w_state_nxt = IDLE;
               w_valid_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ch    <= '0;
         r_sel   <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_sel   <= w_sel_nxt;
         r_word  <= w_word_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
`ifdef MUX_SCAN_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   assign s1         = r_sel[1];
   assign s2         = r_sel[0];
   assign busy       = r_busy;
   assign word_valid = r_valid;
   assign word       = r_word;
`ifdef MUX_SCAN_PARITY_EN
   assign word_par   = r_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// Module   : tb_mux_scan_ctrl
// Purpose  : Self-checking bench for mux_scan_ctrl (SETTLE=2 and SETTLE=0 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

   localparam int SET_A = 2;
   localparam int SET_B = 0;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_v [2];
   logic       ready_v [2];
   logic       d_v     [2];
   logic       s1_v    [2];
   logic       s2_v    [2];
   logic       busy_v  [2];
   logic       valid_v [2];
   logic [3:0] word_v  [2];
   logic [3:0] inp     [2];
`ifdef MUX_SCAN_PARITY_EN
   logic       par_v   [2];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: mode 0=idle, 1=scanning, 2=holding; m_n = edges since start.
   int         m_mode [2];
   int         m_n    [2];
   logic [1:0] m_sel  [2];
   logic       m_busy [2];
   logic       m_valid[2];
   logic [3:0] m_word [2];
   logic       m_par  [2];

   always #5 clk = ~clk;

   // The 4:1 mux being driven.
   assign d_v[0] = inp[0][{s1_v[0], s2_v[0]}];
   assign d_v[1] = inp[1][{s1_v[1], s2_v[1]}];

   mux_scan_ctrl #(.SETTLE(SET_A)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[0]),
      .d          (d_v[0]),
      .s1         (s1_v[0]),
      .s2         (s2_v[0]),
      .busy       (busy_v[0]),
      .word_valid (valid_v[0]),
      .word_ready (ready_v[0]),
      .word       (word_v[0])
`ifdef MUX_SCAN_PARITY_EN
      ,
      .word_par   (par_v[0])
`endif
   );

   mux_scan_ctrl #(.SETTLE(SET_B)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[1]),
      .d          (d_v[1]),
      .s1         (s1_v[1]),
      .s2         (s2_v[1]),
      .busy       (busy_v[1]),
      .word_valid (valid_v[1]),
      .word_ready (ready_v[1]),
      .word       (word_v[1])
`ifdef MUX_SCAN_PARITY_EN
      ,
      .word_par   (par_v[1])
`endif
   );

   function automatic int per_of(input int k);
      return ((k == 0) ? SET_A : SET_B) + 1;
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_mode[k]  <= 0;
            m_n[k]     <= 0;
            m_sel[k]   <= 2'd0;
            m_busy[k]  <= 1'b0;
            m_valid[k] <= 1'b0;
            m_word[k]  <= 4'd0;
            m_par[k]   <= 1'b0;
         end else if (m_mode[k] == 0) begin
            if (start_v[k]) begin
               m_mode[k] <= 1;
               m_n[k]    <= 0;
               m_sel[k]  <= 2'd0;
               m_busy[k] <= 1'b1;
            end
         end else if (m_mode[k] == 1) begin
            m_n[k]   <= m_n[k] + 1;
            m_sel[k] <= ((m_n[k] + 1) >= 4 * per_of(k)) ? 2'd0 : 2'((m_n[k] + 1) / per_of(k));
            if (((m_n[k] + 1) % per_of(k)) == 0)
               m_word[k][((m_n[k] + 1) / per_of(k)) - 1] <= inp[k][((m_n[k] + 1) / per_of(k)) - 1];
            if ((m_n[k] + 1) == 4 * per_of(k)) begin
               m_mode[k]  <= 2;
               m_valid[k] <= 1'b1;
               m_par[k]   <= ^{inp[k][3], m_word[k][2:0]};
            end
         end else begin
            if (ready_v[k]) begin
               m_mode[k]  <= 0;
               m_valid[k] <= 1'b0;
               m_busy[k]  <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk("sel",   k, 32'({s1_v[k], s2_v[k]}), 32'(m_sel[k]));
         chk("busy",  k, 32'(busy_v[k]),  32'(m_busy[k]));
         chk("valid", k, 32'(valid_v[k]), 32'(m_valid[k]));
         chk("word",  k, 32'(word_v[k]),  32'(m_word[k]));
`ifdef MUX_SCAN_PARITY_EN
         chk("par",   k, 32'(par_v[k]),   32'(m_par[k]));
`endif
      end
   end

   // Pulse start for one edge, then count edges after acceptance until valid.
   task automatic run_scan(input int k, output int n);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      n = 0;
      while (!valid_v[k] && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      start_v[0] = 1'b1;
      start_v[1] = 1'b1;
      ready_v[0] = 1'b1;
      ready_v[1] = 1'b1;
      inp[0]     = 4'b0000;
      inp[1]     = 4'b0000;

      // Reset with start held high
      repeat (2) @(negedge clk);
      chk("rst_busy",  0, 32'(busy_v[0]),  32'd0);
      chk("rst_valid", 0, 32'(valid_v[0]), 32'd0);
      chk("rst_word",  0, 32'(word_v[0]),  32'd0);
      chk("rst_sel",   0, 32'({s1_v[0], s2_v[0]}), 32'd0);
      rst_n      = 1'b1;
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      @(negedge clk);

      // Basic scan, SETTLE=2
      inp[0] = 4'b0101;
      run_scan(0, n);
      chk("basic_latency", 0, 32'(n), 32'd12);
      chk("basic_word",    0, 32'(word_v[0]), 32'b0101);
      @(negedge clk);
      chk("basic_valid_1cyc", 0, 32'(valid_v[0]), 32'd0);
      chk("basic_busy_fall",  0, 32'(busy_v[0]),  32'd0);

      // Backpressure with ignored starts, then handshake coinciding with start
      ready_v[0] = 1'b0;
      inp[0]     = 4'b1000;
      run_scan(0, n);
      chk("bp_latency", 0, 32'(n), 32'd12);
      repeat (10) begin
         start_v[0] = 1'b1;
         inp[0]     = 4'b0111;
         @(negedge clk);
      end
      chk("bp_valid_held", 0, 32'(valid_v[0]), 32'd1);
      chk("bp_word_held",  0, 32'(word_v[0]),  32'b1000);
      ready_v[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 0, 32'(valid_v[0]), 32'd0);
      chk("bp_start_ignored", 0, 32'(busy_v[0]),  32'd0);
      start_v[0] = 1'b0;
      @(negedge clk);
      chk("bp_not_queued", 0, 32'(busy_v[0]), 32'd0);
      chk("word_kept",     0, 32'(word_v[0]), 32'b1000);

      // Mid-scan reset at channel 2
      inp[0]     = 4'b1111;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      n = 0;
      while ({s1_v[0], s2_v[0]} != 2'b10 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_ch2", 0, 32'({s1_v[0], s2_v[0]}), 32'd2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
      chk("abort_word", 0, 32'(word_v[0]), 32'd0);
      chk("abort_sel",  0, 32'({s1_v[0], s2_v[0]}), 32'd0);
      run_scan(0, n);
      chk("rescan_word", 0, 32'(word_v[0]), 32'b1111);
      @(negedge clk);

      // SETTLE=0 instance
      inp[1] = 4'b0110;
      run_scan(1, n);
      chk("s0_latency", 1, 32'(n), 32'd4);
      chk("s0_word",    1, 32'(word_v[1]), 32'b0110);
      @(negedge clk);

`ifdef MUX_SCAN_PARITY_EN
      inp[0] = 4'b0111;
      run_scan(0, n);
      chk("par_odd", 0, 32'(par_v[0]), 32'd1);
      @(negedge clk);
      inp[0] = 4'b0110;
      run_scan(0, n);
      chk("par_even", 0, 32'(par_v[0]), 32'd0);
      @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
